// File: rtl/next_pc_arbiter.sv
// Next-PC arbiter: picks the fetch PC from redirect, stall buffer, predecode, BTB/RAS or sequential source.
// Optional: define NPC_RAS_OVERRIDE_EN to let the RAS top replace the BTB target of return branches.
module next_pc_arbiter (
    input  logic        Clk,
    input  logic        Rest,
    input  logic        PcStop,
    input  logic        IcacheStop,
    input  logic        PcFlash,
    input  logic        ReDirectAble,
    input  logic [31:0] ReDirEctPc,
    input  logic        PreNextAble,
    input  logic [31:0] PreNextPc,
    input  logic        BtbAble,
    input  logic [2:0]  BtbType,
    input  logic [31:0] BtbPc,
    input  logic        RasAble,
    input  logic [31:0] RasAddr,
    input  logic        TageAble,
    input  logic        TageMode,
    output logic [31:0] OutPc,
    output logic        PcValid,
    output logic [2:0]  PcSrc,
    output logic        PendValid
);
    localparam logic [31:0] RESET_PC  = 32'h1C00_0000;
    localparam logic [2:0]  SRC_SEQ   = 3'd0;
    localparam logic [2:0]  SRC_BTB   = 3'd1;
`ifdef NPC_RAS_OVERRIDE_EN
    localparam logic [2:0]  SRC_RAS   = 3'd2;
`endif
    localparam logic [2:0]  SRC_PRE   = 3'd3;
    localparam logic [2:0]  SRC_REDIR = 3'd4;
    localparam logic [2:0]  SRC_PEND  = 3'd5;
    localparam logic [2:0]  SRC_RESET = 3'd7;

    typedef enum logic [1:0] {RUN, STALL, STALL_PEND} state_e;

    state_e      state_q, state_d;
    logic [31:0] outPc_q, outPc_d;
    logic        pcValid_q, pcValid_d;
    logic [2:0]  pcSrc_q, pcSrc_d;
    logic [31:0] pendPc_q, pendPc_d;
    logic        pendIsRedir_q, pendIsRedir_d;
    logic        boot_q, boot_d;

    logic        stall;
    logic        pendValid;
    logic [31:0] seqPc;
    logic [2:0]  seqSrc;
    logic [31:0] predPc;
    logic [2:0]  predSrc;

`ifndef NPC_RAS_OVERRIDE_EN
    logic unusedRas;
    assign unusedRas = ^{RasAble, RasAddr};
`endif

    assign stall     = PcStop | IcacheStop;
    assign pendValid = (state_q == STALL_PEND);

    // Until the first fetch leaves, the "sequential" PC is the reset vector itself.
    assign seqPc  = boot_q ? RESET_PC : ({outPc_q[31:4], 4'b0000} + 32'd16);
    assign seqSrc = boot_q ? SRC_RESET : SRC_SEQ;

    always_comb begin
        predPc  = seqPc;
        predSrc = seqSrc;
        if (BtbAble) begin
            case (BtbType)
                3'b001: begin
                    if (TageAble && TageMode) begin
                        predPc  = BtbPc;
                        predSrc = SRC_BTB;
                    end
                end
                3'b010, 3'b011: begin
                    predPc  = BtbPc;
                    predSrc = SRC_BTB;
                end
                3'b100: begin
`ifdef NPC_RAS_OVERRIDE_EN
                    if (RasAble) begin
                        predPc  = RasAddr;
                        predSrc = SRC_RAS;
                    end else begin
                        predPc  = BtbPc;
                        predSrc = SRC_BTB;
                    end
`else
                    predPc  = BtbPc;
                    predSrc = SRC_BTB;
`endif
                end
                default: ;
            endcase
        end
    end

    // A flush alone only kills the fetch; a flush carrying a redirect is treated as a plain redirect.
    always_comb begin
        state_d       = state_q;
        outPc_d       = outPc_q;
        pcValid_d     = 1'b0;
        pcSrc_d       = pcSrc_q;
        pendPc_d      = pendPc_q;
        pendIsRedir_d = pendIsRedir_q;
        boot_d        = boot_q;
        if (PcFlash && !ReDirectAble) begin
            pendIsRedir_d = 1'b0;
            state_d       = stall ? STALL : RUN;
        end else if (stall) begin
            if (ReDirectAble) begin
                pendPc_d      = ReDirEctPc;
                pendIsRedir_d = 1'b1;
                state_d       = STALL_PEND;
            end else if (PreNextAble && !(pendValid && pendIsRedir_q)) begin
                pendPc_d      = PreNextPc;
                pendIsRedir_d = 1'b0;
                state_d       = STALL_PEND;
            end else if (state_q == RUN) begin
                state_d = STALL;
            end
        end else begin
            pcValid_d     = 1'b1;
            pendIsRedir_d = 1'b0;
            boot_d        = 1'b0;
            state_d       = RUN;
            if (ReDirectAble) begin
                outPc_d = ReDirEctPc;
                pcSrc_d = SRC_REDIR;
            end else if (pendValid) begin
                outPc_d = pendPc_q;
                pcSrc_d = SRC_PEND;
            end else if (PreNextAble) begin
                outPc_d = PreNextPc;
                pcSrc_d = SRC_PRE;
            end else begin
                outPc_d = predPc;
                pcSrc_d = predSrc;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_q       <= RUN;
            outPc_q       <= RESET_PC;
            pcValid_q     <= 1'b0;
            pcSrc_q       <= SRC_RESET;
            pendPc_q      <= 32'd0;
            pendIsRedir_q <= 1'b0;
            boot_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            outPc_q       <= outPc_d;
            pcValid_q     <= pcValid_d;
            pcSrc_q       <= pcSrc_d;
            pendPc_q      <= pendPc_d;
            pendIsRedir_q <= pendIsRedir_d;
            boot_q        <= boot_d;
        end
    end

    assign OutPc     = outPc_q;
    assign PcValid   = pcValid_q;
    assign PcSrc     = pcSrc_q;
    assign PendValid = pendValid;

endmodule

// File: tb/tb_next_pc_arbiter.sv
// Self-checking bench for next_pc_arbiter: directed scenarios then randomized traffic vs a rule-level model.
// Honours NPC_RAS_OVERRIDE_EN the same way the design does.
module tb_next_pc_arbiter;
    localparam logic [31:0] RESET_PC = 32'h1C00_0000;

    logic        Clk;
    logic        Rest;
    logic        PcStop, IcacheStop, PcFlash;
    logic        ReDirectAble, PreNextAble, BtbAble, RasAble, TageAble, TageMode;
    logic [31:0] ReDirEctPc, PreNextPc, BtbPc, RasAddr;
    logic [2:0]  BtbType;
    logic [31:0] OutPc;
    logic        PcValid;
    logic [2:0]  PcSrc;
    logic        PendValid;

    typedef struct {
        logic [31:0] pc;
        bit          isRedir;
    } pend_t;

    pend_t       pendQ[$];
    logic [31:0] mOut;
    logic        mValid;
    logic [2:0]  mSrc;
    bit          mBoot;
    int          nVectors = 0;
    int          nMiss    = 0;

    next_pc_arbiter dut (
        .Clk(Clk), .Rest(Rest), .PcStop(PcStop), .IcacheStop(IcacheStop), .PcFlash(PcFlash),
        .ReDirectAble(ReDirectAble), .ReDirEctPc(ReDirEctPc),
        .PreNextAble(PreNextAble), .PreNextPc(PreNextPc),
        .BtbAble(BtbAble), .BtbType(BtbType), .BtbPc(BtbPc),
        .RasAble(RasAble), .RasAddr(RasAddr), .TageAble(TageAble), .TageMode(TageMode),
        .OutPc(OutPc), .PcValid(PcValid), .PcSrc(PcSrc), .PendValid(PendValid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic idleInputs;
        PcStop = 0; IcacheStop = 0; PcFlash = 0;
        ReDirectAble = 0; ReDirEctPc = 0; PreNextAble = 0; PreNextPc = 0;
        BtbAble = 0; BtbType = 0; BtbPc = 0; RasAble = 0; RasAddr = 0;
        TageAble = 0; TageMode = 0;
    endtask

    task automatic modelReset;
        mOut = RESET_PC; mValid = 0; mSrc = 3'd7; mBoot = 1; pendQ.delete();
    endtask

    // Reference: one fetch decision per cycle, derived straight from the priority rules.
    task automatic modelStep;
        logic [31:0] nPc;
        logic [2:0]  nSrc;
        pend_t       e;
        bit          stallNow;
        stallNow = PcStop || IcacheStop;
        if (PcFlash && !ReDirectAble) begin
            mValid = 0;
            pendQ.delete();
        end else if (stallNow) begin
            mValid = 0;
            if (ReDirectAble) begin
                e.pc = ReDirEctPc; e.isRedir = 1;
                pendQ.delete(); pendQ.push_back(e);
            end else if (PreNextAble && !(pendQ.size() > 0 && pendQ[0].isRedir)) begin
                e.pc = PreNextPc; e.isRedir = 0;
                pendQ.delete(); pendQ.push_back(e);
            end
        end else begin
            nPc  = mBoot ? RESET_PC : (mOut & 32'hFFFF_FFF0) + 32'd16;
            nSrc = mBoot ? 3'd7 : 3'd0;
            if (BtbAble) begin
                if (BtbType == 3'd1 && TageAble && TageMode) begin nPc = BtbPc; nSrc = 3'd1; end
                if (BtbType == 3'd2 || BtbType == 3'd3)     begin nPc = BtbPc; nSrc = 3'd1; end
                if (BtbType == 3'd4) begin
`ifdef NPC_RAS_OVERRIDE_EN
                    if (RasAble) begin nPc = RasAddr; nSrc = 3'd2; end
                    else         begin nPc = BtbPc;   nSrc = 3'd1; end
`else
                    nPc = BtbPc; nSrc = 3'd1;
`endif
                end
            end
            if (PreNextAble)         begin nPc = PreNextPc;   nSrc = 3'd3; end
            if (pendQ.size() > 0)    begin nPc = pendQ[0].pc; nSrc = 3'd5; end
            if (ReDirectAble)        begin nPc = ReDirEctPc;  nSrc = 3'd4; end
            mOut = nPc; mSrc = nSrc; mValid = 1; mBoot = 0;
            pendQ.delete();
        end
    endtask

    task automatic checkOutput(input string tag);
        logic expPend;
        expPend = (pendQ.size() != 0);
        nVectors++;
        assert (OutPc === mOut) else begin
            nMiss++; $error("FAIL %s OutPc got %h exp %h", tag, OutPc, mOut);
        end
        nVectors++;
        assert (PcValid === mValid) else begin
            nMiss++; $error("FAIL %s PcValid got %b exp %b", tag, PcValid, mValid);
        end
        nVectors++;
        assert (PcSrc === mSrc) else begin
            nMiss++; $error("FAIL %s PcSrc got %0d exp %0d", tag, PcSrc, mSrc);
        end
        nVectors++;
        assert (PendValid === expPend) else begin
            nMiss++; $error("FAIL %s PendValid got %b exp %b", tag, PendValid, expPend);
        end
    endtask

    task automatic applyStimulus(input string tag);
        modelStep();
        @(posedge Clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkConst(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        assert (got === exp) else begin
            nMiss++; $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        idleInputs();
        Rest = 1;
        #2 Rest = 0;
        #1 modelReset();
        checkOutput("reset_async");
        checkConst("reset_src", {29'd0, PcSrc}, 32'd7);
        @(posedge Clk); #1;
        checkOutput("reset_held");
        Rest = 1;

        applyStimulus("boot_fetch");
        checkConst("boot_pc", OutPc, 32'h1C00_0000);
        applyStimulus("seq1");
        checkConst("seq1_pc", OutPc, 32'h1C00_0010);
        applyStimulus("seq2");
        checkConst("seq2_pc", OutPc, 32'h1C00_0020);

        ReDirectAble = 1; ReDirEctPc = 32'h1C00_0040;
        applyStimulus("redir_40");
        idleInputs();
        BtbAble = 1; BtbType = 3'b001; TageAble = 1; TageMode = 0; BtbPc = 32'h1C00_0100;
        applyStimulus("cond_not_taken");
        checkConst("cond_nt_pc", OutPc, 32'h1C00_0050);
        TageMode = 1;
        applyStimulus("cond_taken");
        checkConst("cond_t_pc", OutPc, 32'h1C00_0100);

        idleInputs();
        IcacheStop = 1; PreNextAble = 1; PreNextPc = 32'h1C00_0200;
        applyStimulus("stall_c1_prenext");
        PreNextAble = 0; ReDirectAble = 1; ReDirEctPc = 32'h1C00_0300;
        applyStimulus("stall_c2_redir");
        ReDirectAble = 0; PreNextAble = 1; PreNextPc = 32'h1C00_0222;
        applyStimulus("stall_c3_prenext_blocked");
        checkConst("stall_pend", {31'd0, PendValid}, 32'd1);
        idleInputs();
        applyStimulus("release_pend");
        checkConst("release_pc", OutPc, 32'h1C00_0300);

        PcStop = 1; ReDirectAble = 1; ReDirEctPc = 32'h1C00_0300;
        applyStimulus("stall_redir_300");
        idleInputs();
        ReDirectAble = 1; ReDirEctPc = 32'h1C00_0400;
        applyStimulus("release_redir_wins");
        checkConst("release_redir_pc", OutPc, 32'h1C00_0400);

        idleInputs();
        BtbAble = 1; BtbType = 3'b100; RasAble = 1; RasAddr = 32'h1C00_0500; BtbPc = 32'h1C00_0600;
        applyStimulus("return_ras");
`ifdef NPC_RAS_OVERRIDE_EN
        checkConst("return_pc", OutPc, 32'h1C00_0500);
`else
        checkConst("return_pc", OutPc, 32'h1C00_0600);
`endif

        idleInputs();
        ReDirectAble = 1; ReDirEctPc = 32'hFFFF_FFF4;
        applyStimulus("redir_top");
        idleInputs();
        applyStimulus("wrap");
        checkConst("wrap_pc", OutPc, 32'h0000_0000);

        PcStop = 1; PreNextAble = 1; PreNextPc = 32'h1C00_0700;
        applyStimulus("flush_setup");
        PreNextAble = 0; PcFlash = 1;
        applyStimulus("flush_clears");
        PcFlash = 1; PcStop = 0; ReDirectAble = 1; ReDirEctPc = 32'h1C00_0800;
        applyStimulus("flush_with_redir");
        idleInputs();
        ReDirectAble = 1; PreNextAble = 1; ReDirEctPc = 32'h1C00_0900; PreNextPc = 32'h1C00_0A00;
        applyStimulus("redir_beats_prenext");

        idleInputs();
        IcacheStop = 1; ReDirectAble = 1; ReDirEctPc = 32'h1C00_0B00;
        applyStimulus("pend_before_reset");
        #2 Rest = 0;
        #1 modelReset();
        checkOutput("reset_mid_stall");
        @(posedge Clk); #1;
        Rest = 1;
        applyStimulus("post_reset_stalled");
        idleInputs();
        applyStimulus("post_reset_boot");

        for (int i = 0; i < 400; i++) begin
            PcStop       = ($urandom_range(0, 7) == 0);
            IcacheStop   = ($urandom_range(0, 5) == 0);
            PcFlash      = ($urandom_range(0, 11) == 0);
            ReDirectAble = ($urandom_range(0, 6) == 0);
            PreNextAble  = ($urandom_range(0, 6) == 0);
            BtbAble      = ($urandom_range(0, 1) == 1);
            BtbType      = 3'($urandom_range(0, 7));
            RasAble      = ($urandom_range(0, 1) == 1);
            TageAble     = ($urandom_range(0, 1) == 1);
            TageMode     = ($urandom_range(0, 1) == 1);
            ReDirEctPc   = $urandom;
            PreNextPc    = $urandom;
            BtbPc        = $urandom;
            RasAddr      = $urandom;
            applyStimulus("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end
endmodule
